ipg_msg_assembler: RTL and testbench
====================================

# ipg_msg_assembler

Reassembles decoded inter-packet-gap (IPG) control blocks into complete read-request, write-request and read-response messages. It sits directly downstream of the IPG receive decoder and consumes that decoder's 64-bit block output and its per-type valid strobes. It emits one packed message at a time over a valid/ready handshake, and it reports framing errors and dropped blocks.

## Interface
- `MAX_WORDS`, default 4: maximum number of 56-bit payload words per message. Legal range is 1–15.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `in_data`  in  64: decoded IPG block. `[7:0]` is the block type; `[63:8]` is the payload.
- `in_rreq_valid`  in  1: `in_data` holds a read-request block this cycle.
- `in_wreq_valid`  in  1: `in_data` holds a write-request block this cycle.
- `in_rresp_valid`  in  1: `in_data` holds a read-response block this cycle.
- `msg_data`  out  `56*MAX_WORDS`: packed message. Word k is at `[56*k +: 56]`; unused words are zero.
- `msg_words`  out  4: number of valid words in the message, 1..`MAX_WORDS`.
- `msg_type`  out  2: message type. 2'b01 = read, 2'b10 = write, 2'b11 = response.
- `msg_valid`  out  1: a message is presented.
- `msg_ready`  in  1: the consumer accepts the message.
- `err_seq`  out  1: one-cycle pulse on a framing error.
- `err_overflow`  out  1: one-cycle pulse when a message exceeds `MAX_WORDS`.
- `drop_count`  out  16: saturating count of ignored blocks.

## Operation
**Block decoding**
- A block is present when exactly one `in_*_valid` is high. The message type comes from which valid is high.
- If more than one valid is high, the block is ignored, `err_seq` pulses and `drop_count` increments.
- Position comes from `in_data[7:4]`: 0 = FIRST, 1 = MIDDLE, 2 = LAST. Any other value is treated like the two-or-more-valids case.

**States**
- IDLE:
  - FIRST: word 0 = payload, count = 1, latch the type, go to COLLECT.
  - MIDDLE: this is a complete single-word message. Load it and go to HOLD.
  - LAST: `err_seq` pulses, `drop_count` increments, stay in IDLE.
- COLLECT:
  - MIDDLE or LAST with a matching type: append the payload at index `count` and increment `count`.
    - LAST goes to HOLD.
    - If the append would make `count` exceed `MAX_WORDS`: `err_overflow` pulses, the partial message is discarded, and the state goes to DISCARD. For LAST, the state goes to IDLE instead.
  - MIDDLE or LAST with a mismatched type: `err_seq` pulses, the partial message is discarded, go to IDLE.
  - FIRST of any type: `err_seq` pulses, the partial message is discarded, and a new message starts from this block. Stay in COLLECT.
- DISCARD:
  - MIDDLE: ignored, `drop_count` increments.
  - LAST: ignored, `drop_count` increments, go to IDLE.
  - FIRST: start a new message, go to COLLECT.
- HOLD: `msg_valid`=1 and all `msg_*` outputs are stable.
  - On `msg_valid && msg_ready`: the message is transferred, and any block present in the same cycle is processed exactly as in IDLE.
  - A block present while `msg_ready`=0 is ignored and `drop_count` increments.
  - There is no upstream backpressure.

**Arithmetic and reset**
- `drop_count` saturates at 16'hFFFF.
- At the start of each message, the assembly register is cleared to zero.
- Reset: state IDLE. `msg_data`=0, `msg_words`=0, `msg_type`=0, `msg_valid`=0, `err_seq`=0, `err_overflow`=0, `drop_count`=0.
- Reset mid-message discards the partial message silently, with no error pulse.

## Timing
- All outputs are registered.
- Latency: a LAST block (or a lone MIDDLE block) sampled at edge t gives `msg_valid`=1 after edge t, i.e. visible in cycle t+1.
- Transfer happens on the edge where `msg_valid && msg_ready`.
  - `msg_valid` drops after that edge, unless a lone MIDDLE block present in the same cycle reloads it. In that case `msg_valid` stays high with the new contents.
- Error pulses and `drop_count` updates appear in the cycle after the offending block.
- Back-to-back blocks every cycle are supported. Minimum message spacing is one cycle, provided `msg_ready` is held high.

## Test plan
- Read FIRST 0x0a (payload 56'h11…11), MIDDLE 0x1a (56'h22…22), LAST 0x2a (56'h33…33) on consecutive cycles, `msg_ready`=1 → `msg_valid` for 1 cycle, `msg_type`=01, `msg_words`=3, word0/1/2 match the payloads, word3=0.
- Lone write MIDDLE 0x1c in IDLE with `msg_ready`=0 for 5 cycles, plus two more write blocks during those cycles → message held stable with `msg_words`=1, `msg_type`=10; `drop_count`=2.
- FIRST 0x0a followed by MIDDLE 0x1b (response valid) → `err_seq` pulse, no message, state IDLE; a following 0x1a then delivers a 1-word read message.
- `MAX_WORDS`=4: FIRST plus 4 MIDDLE blocks plus LAST, all response type → `err_overflow` pulse on the 4th MIDDLE, the trailing LAST increments `drop_count`, no `msg_valid`.
- LAST 0x2b in IDLE, then two valids high together → two `err_seq` pulses, `drop_count`=2; then force `drop_count` near 16'hFFFF via repeated drops → it holds at 16'hFFFF.
- `rst` asserted after FIRST+MIDDLE, then LAST applied → no `msg_valid`, no `err_seq`, all outputs zero, `err_seq` pulses for the orphan LAST.

Source files
------------

// File: rtl/ipg_msg_assembler.sv
// Rebuilds FIRST/MIDDLE/LAST IPG blocks into one packed message; the message is valid the cycle after its closing block.
// No upstream backpressure: blocks arriving while a message waits unaccepted are dropped and counted.
module ipg_msg_assembler #(
    parameter int MAX_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [63:0]               in_data,
    input  logic                      in_rreq_valid,
    input  logic                      in_wreq_valid,
    input  logic                      in_rresp_valid,
    output logic [56*MAX_WORDS-1:0]   msg_data,
    output logic [3:0]                msg_words,
    output logic [1:0]                msg_type,
    output logic                      msg_valid,
    input  logic                      msg_ready,
    output logic                      err_seq,
    output logic                      err_overflow,
    output logic [15:0]               drop_count
);

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, HOLD} state_t;

    state_t                   state, state_n;
    logic [56*MAX_WORDS-1:0]  data_n;
    logic [3:0]               words_n;
    logic [1:0]               type_n;
    logic                     seq_n, ovf_n, drop_inc, load_one, append;

    logic [1:0]  nvalid;
    logic [1:0]  blk_type;
    logic [3:0]  pos;
    logic [55:0] payload;
    logic        bad, is_first, is_mid, is_last;
    logic        unused_bits;

    assign nvalid   = {1'b0, in_rreq_valid} + {1'b0, in_wreq_valid} + {1'b0, in_rresp_valid};
    assign blk_type = in_rreq_valid ? 2'b01 : (in_wreq_valid ? 2'b10 : 2'b11);
    assign pos      = in_data[7:4];
    assign payload  = in_data[63:8];
    assign unused_bits = ^in_data[3:0];

    // Multi-valid and unknown positions both count as malformed blocks.
    assign bad      = (nvalid > 2'd1) || (nvalid == 2'd1 && pos > 4'd2);
    assign is_first = (nvalid == 2'd1) && (pos == 4'd0);
    assign is_mid   = (nvalid == 2'd1) && (pos == 4'd1);
    assign is_last  = (nvalid == 2'd1) && (pos == 4'd2);

    always_comb begin
        state_n  = state;
        data_n   = msg_data;
        words_n  = msg_words;
        type_n   = msg_type;
        seq_n    = 1'b0;
        ovf_n    = 1'b0;
        drop_inc = 1'b0;
        load_one = 1'b0;
        append   = 1'b0;
        if (bad) begin
            seq_n    = 1'b1;
            drop_inc = 1'b1;
            if (state == HOLD && msg_ready) state_n = IDLE;
        end else if (state == IDLE || (state == HOLD && msg_ready)) begin
            // A transfer frees the output, so this cycle's block behaves as in IDLE.
            state_n = IDLE;
            if (is_first) begin
                load_one = 1'b1;
                state_n  = COLLECT;
            end else if (is_mid) begin
                load_one = 1'b1;
                state_n  = HOLD;
            end else if (is_last) begin
                seq_n    = 1'b1;
                drop_inc = 1'b1;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (is_first) begin
                        seq_n    = 1'b1;
                        load_one = 1'b1;
                    end else if (is_mid || is_last) begin
                        if (blk_type != msg_type) begin
                            seq_n   = 1'b1;
                            state_n = IDLE;
                        end else if (msg_words == 4'(MAX_WORDS)) begin
                            ovf_n   = 1'b1;
                            state_n = is_last ? IDLE : DISCARD;
                        end else begin
                            append  = 1'b1;
                            words_n = msg_words + 4'd1;
                            if (is_last) state_n = HOLD;
                        end
                    end
                end
                DISCARD: begin
                    if (is_first) begin
                        load_one = 1'b1;
                        state_n  = COLLECT;
                    end else if (is_mid) begin
                        drop_inc = 1'b1;
                    end else if (is_last) begin
                        drop_inc = 1'b1;
                        state_n  = IDLE;
                    end
                end
                HOLD: begin
                    if (is_first || is_mid || is_last) drop_inc = 1'b1;
                end
                default: ;
            endcase
        end
        if (load_one) begin
            data_n        = '0;
            data_n[55:0]  = payload;
            words_n       = 4'd1;
            type_n        = blk_type;
        end
        for (int k = 0; k < MAX_WORDS; k++) begin
            if (append && msg_words == 4'(k)) data_n[56*k +: 56] = payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            msg_data     <= '0;
            msg_words    <= 4'd0;
            msg_type     <= 2'd0;
            msg_valid    <= 1'b0;
            err_seq      <= 1'b0;
            err_overflow <= 1'b0;
            drop_count   <= 16'd0;
        end else begin
            state        <= state_n;
            msg_data     <= data_n;
            msg_words    <= words_n;
            msg_type     <= type_n;
            msg_valid    <= (state_n == HOLD);
            err_seq      <= seq_n;
            err_overflow <= ovf_n;
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ipg_msg_assembler.sv
// Directed and randomized checks of ipg_msg_assembler against a queue-based message model.
module tb_ipg_msg_assembler;
    localparam int MW = 4;
    localparam bit [2:0] RD = 3'b001, WR = 3'b010, RS = 3'b100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [63:0]       in_data;
    logic              in_rreq_valid, in_wreq_valid, in_rresp_valid, msg_ready;
    logic [56*MW-1:0]  msg_data;
    logic [3:0]        msg_words;
    logic [1:0]        msg_type;
    logic              msg_valid, err_seq, err_overflow;
    logic [15:0]       drop_count;

    ipg_msg_assembler #(.MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data),
        .in_rreq_valid(in_rreq_valid), .in_wreq_valid(in_wreq_valid), .in_rresp_valid(in_rresp_valid),
        .msg_data(msg_data), .msg_words(msg_words), .msg_type(msg_type),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .err_seq(err_seq), .err_overflow(err_overflow), .drop_count(drop_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a pending message, an in-progress word list, and a skip flag.
    bit         m_pend, m_coll, m_skip, m_seq, m_ovf;
    bit [1:0]   m_ctype, m_otype;
    bit [55:0]  m_q[$];
    bit [55:0]  m_out[$];
    int         m_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bump();
        if (m_drop < 65535) m_drop++;
    endtask

    task automatic model(input bit [2:0] v, input bit [63:0] d, input bit rdy);
        int        nv;
        int        p_pos;
        bit [1:0]  t;
        bit [55:0] p;
        nv    = int'(v[0]) + int'(v[1]) + int'(v[2]);
        p_pos = int'(d[7:4]);
        t     = v[0] ? 2'b01 : (v[1] ? 2'b10 : 2'b11);
        p     = d[63:8];
        m_seq = 0;
        m_ovf = 0;
        if (m_pend && rdy) m_pend = 0;
        if (nv == 0) begin
        end else if (nv > 1 || p_pos > 2) begin
            m_seq = 1;
            bump();
        end else if (m_pend) begin
            bump();
        end else if (m_coll) begin
            if (p_pos == 0) begin
                m_seq = 1; m_q = {p}; m_ctype = t;
            end else if (t != m_ctype) begin
                m_seq = 1; m_coll = 0;
            end else if (m_q.size() == MW) begin
                m_ovf = 1; m_coll = 0; m_skip = (p_pos == 1);
            end else begin
                m_q.push_back(p);
                if (p_pos == 2) begin
                    m_coll = 0; m_out = m_q; m_otype = t; m_pend = 1;
                end
            end
        end else if (m_skip) begin
            if (p_pos == 0) begin
                m_skip = 0; m_coll = 1; m_q = {p}; m_ctype = t;
            end else begin
                bump();
                if (p_pos == 2) m_skip = 0;
            end
        end else begin
            if (p_pos == 0) begin
                m_coll = 1; m_q = {p}; m_ctype = t;
            end else if (p_pos == 1) begin
                m_out = {p}; m_otype = t; m_pend = 1;
            end else begin
                m_seq = 1;
                bump();
            end
        end
    endtask

    task automatic check_outputs();
        chk("msg_valid", msg_valid, m_pend);
        chk("err_seq", err_seq, m_seq);
        chk("err_overflow", err_overflow, m_ovf);
        chk("drop_count", drop_count, m_drop[15:0]);
        if (m_pend) begin
            chk("msg_words", msg_words, m_out.size());
            chk("msg_type", msg_type, m_otype);
            for (int k = 0; k < MW; k++)
                chk($sformatf("msg_word%0d", k), msg_data[56*k +: 56], (k < m_out.size()) ? m_out[k] : 56'h0);
        end
    endtask

    task automatic step(input bit [2:0] v, input bit [63:0] d, input bit rdy);
        {in_rresp_valid, in_wreq_valid, in_rreq_valid} = v;
        in_data   = d;
        msg_ready = rdy;
        @(posedge clk);
        #1;
        model(v, d, rdy);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {in_rresp_valid, in_wreq_valid, in_rreq_valid} = 3'b000;
        in_data   = 64'h0;
        msg_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pend = 0; m_coll = 0; m_skip = 0; m_seq = 0; m_ovf = 0; m_drop = 0;
        m_q.delete();
        m_out.delete();
        chk("rst_msg_valid", msg_valid, 1'b0);
        chk("rst_msg_data_nonzero", msg_data != '0, 1'b0);
        chk("rst_msg_words", msg_words, 4'd0);
        chk("rst_msg_type", msg_type, 2'd0);
        chk("rst_err_seq", err_seq, 1'b0);
        chk("rst_err_overflow", err_overflow, 1'b0);
        chk("rst_drop_count", drop_count, 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_data = 64'h0;
        in_rreq_valid = 0; in_wreq_valid = 0; in_rresp_valid = 0;
        msg_ready = 0;

        // Three-word read message
        do_reset();
        step(RD, {56'h11111111111111, 8'h0a}, 1);
        step(RD, {56'h22222222222222, 8'h1a}, 1);
        step(RD, {56'h33333333333333, 8'h2a}, 1);
        chk("t1_valid", msg_valid, 1'b1);
        chk("t1_words", msg_words, 4'd3);
        chk("t1_type", msg_type, 2'b01);
        chk("t1_word0", msg_data[55:0], 56'h11111111111111);
        chk("t1_word1", msg_data[111:56], 56'h22222222222222);
        chk("t1_word2", msg_data[167:112], 56'h33333333333333);
        chk("t1_word3", msg_data[223:168], 56'h0);
        step(3'b000, 64'h0, 1);
        chk("t1_valid_after", msg_valid, 1'b0);

        // Lone write MIDDLE held under msg_ready=0 while more blocks arrive
        do_reset();
        step(WR, {56'hABCDEF01234567, 8'h1c}, 0);
        step(3'b000, 64'h0, 0);
        step(WR, {56'h55555555555555, 8'h0c}, 0);
        step(3'b000, 64'h0, 0);
        step(WR, {56'h66666666666666, 8'h2c}, 0);
        step(3'b000, 64'h0, 0);
        chk("t2_valid", msg_valid, 1'b1);
        chk("t2_words", msg_words, 4'd1);
        chk("t2_type", msg_type, 2'b10);
        chk("t2_word0", msg_data[55:0], 56'hABCDEF01234567);
        chk("t2_drop", drop_count, 16'd2);
        step(3'b000, 64'h0, 1);
        chk("t2_valid_after", msg_valid, 1'b0);

        // Type mismatch inside a message, then a lone read MIDDLE
        do_reset();
        step(RD, {56'h01010101010101, 8'h0a}, 1);
        step(RS, {56'h02020202020202, 8'h1b}, 1);
        chk("t3_err_seq", err_seq, 1'b1);
        chk("t3_no_valid", msg_valid, 1'b0);
        step(RD, {56'h03030303030303, 8'h1a}, 1);
        chk("t3_valid", msg_valid, 1'b1);
        chk("t3_words", msg_words, 4'd1);
        chk("t3_type", msg_type, 2'b01);
        chk("t3_word0", msg_data[55:0], 56'h03030303030303);
        step(3'b000, 64'h0, 1);

        // Overflow: FIRST + 4 MIDDLE + LAST, response type
        do_reset();
        step(RS, {56'h10, 8'h0b}, 1);
        for (int i = 0; i < 4; i++) step(RS, {56'(i + 32), 8'h1b}, 1);
        chk("t4_err_overflow", err_overflow, 1'b1);
        step(RS, {56'h99, 8'h2b}, 1);
        chk("t4_drop", drop_count, 16'd1);
        chk("t4_no_valid", msg_valid, 1'b0);
        chk("t4_no_seq", err_seq, 1'b0);

        // Orphan LAST, then two valids together
        do_reset();
        step(RS, {56'h77, 8'h2b}, 1);
        chk("t5_seq_last", err_seq, 1'b1);
        step(3'b011, {56'h88, 8'h0a}, 1);
        chk("t5_seq_multi", err_seq, 1'b1);
        chk("t5_drop", drop_count, 16'd2);

        // Reset mid-message, then the orphan LAST
        do_reset();
        step(RD, {56'hA1, 8'h0a}, 1);
        step(RD, {56'hA2, 8'h1a}, 1);
        do_reset();
        step(RD, {56'hA3, 8'h2a}, 1);
        chk("t6_seq", err_seq, 1'b1);
        chk("t6_no_valid", msg_valid, 1'b0);

        // Randomized traffic
        do_reset();
        begin
            bit [1:0] cur;
            cur = 2'b01;
            for (int i = 0; i < 3000; i++) begin
                bit [2:0]  v;
                bit [63:0] d;
                int        r;
                int        rp;
                if ($urandom_range(0, 19) == 0) cur = 2'($urandom_range(1, 3));
                r = $urandom_range(0, 99);
                if (r < 65)      v = (cur == 2'b01) ? RD : ((cur == 2'b10) ? WR : RS);
                else if (r < 70) v = 3'b001 << $urandom_range(0, 2);
                else if (r < 73) v = (r == 70) ? 3'b011 : ((r == 71) ? 3'b110 : 3'b111);
                else             v = 3'b000;
                d = {$urandom, $urandom};
                rp = $urandom_range(0, 99);
                if (rp < 22)      d[7:4] = 4'd0;
                else if (rp < 65) d[7:4] = 4'd1;
                else if (rp < 95) d[7:4] = 4'd2;
                else              d[7:4] = 4'($urandom_range(3, 15));
                step(v, d, $urandom_range(0, 3) != 0);
            end
        end

        // Drive drop_count into saturation
        for (int i = 0; i < 65540; i++) step(3'b011, 64'h0, 1);
        chk("sat_drop", drop_count, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
